// File: rtl/obstacle_row.sv
`default_nettype none
// ============================================================================
// obstacle_row: one lane of wrapping cars or logs plus frog collision/ride logic
// Revision: 1.0
// ============================================================================
module obstacle_row #(
    parameter int N_OBJ    = 4,
    parameter int OBJ_W    = 80,
    parameter int FROG_W   = 40,
    parameter int SCREEN_W = 640
) (
    input  logic                   frame_clk,
    input  logic                   Reset,
    input  logic                   Load,
    input  logic                   Pause,
    input  logic                   Mode,
    input  logic [3:0]             Number_Objs,
    input  logic [7:0]             Gap_Size,
    input  logic [4:0]             Speed,
    input  logic                   Direction,
    input  logic [10:0]            Row_Y,
    input  logic [10:0]            Frog_X,
    input  logic [10:0]            Frog_Y,
    output logic [N_OBJ-1:0][10:0] Obj_X,
    output logic [N_OBJ-1:0]       Obj_Active,
    output logic                   Hit,
    output logic                   Ride_Step,
    output logic                   Ride_Dir
);

    localparam int          TRACK_L  = SCREEN_W + OBJ_W;
    localparam logic [10:0] LAST_POS = 11'(TRACK_L - 1);
    localparam logic [15:0] TRACK_LW = 16'(TRACK_L);
    localparam logic [3:0]  MAX_OBJ  = 4'(N_OBJ);
    localparam logic [11:0] REACH    = 12'(FROG_W + OBJ_W);

    logic [3:0]       active_cnt;
    logic [4:0]       presc;
    logic [4:0]       presc_limit;
    logic             running;
    logic             move;
    logic             in_lane;
    logic [11:0]      frog_left;
    logic [11:0]      frog_reach;
    logic [N_OBJ-1:0] overlap;
    logic             any_overlap;

    assign active_cnt  = (Number_Objs > MAX_OBJ) ? MAX_OBJ : Number_Objs;
    assign presc_limit = 5'd31 - Speed;
    assign running     = (Speed != 5'd0) && !Pause;
    // >= so a speed increase that lowers the limit below the count still fires.
    assign move        = running && (presc >= presc_limit);
    assign in_lane     = (Frog_Y == Row_Y);
    assign frog_left   = {1'b0, Frog_X};
    assign frog_reach  = frog_left + REACH;
    assign any_overlap = |overlap;

    generate
        for (genvar i = 0; i < N_OBJ; i++) begin : g_slot
            logic [15:0] start_raw;
            logic [10:0] start_pos;
            logic [10:0] step_pos;
            logic [10:0] pos;

            assign start_raw = 16'(i) * (16'(Gap_Size) + 16'(OBJ_W));
            assign start_pos = 11'(start_raw % TRACK_LW);

            always_comb begin
                step_pos = pos;
                if (Direction) begin
                    step_pos = (pos == LAST_POS) ? 11'd0 : pos + 11'd1;
                end else begin
                    step_pos = (pos == 11'd0) ? LAST_POS : pos - 11'd1;
                end
            end

            always_ff @(posedge frame_clk) begin
                if (Reset || Load) begin
                    pos <= start_pos;
                end else if (move) begin
                    pos <= step_pos;
                end
            end

            assign Obj_X[i]      = pos;
            assign Obj_Active[i] = (4'(i) < active_cnt);
            // Track position is the right edge + 1, so the box spans [pos-OBJ_W, pos-1].
            assign overlap[i]    = Obj_Active[i] && in_lane &&
                                   (frog_left < {1'b0, pos}) &&
                                   (frog_reach > {1'b0, pos});
        end
    endgenerate

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            presc     <= 5'd0;
            Hit       <= 1'b0;
            Ride_Step <= 1'b0;
            Ride_Dir  <= 1'b0;
        end else if (Load) begin
            presc     <= 5'd0;
            Hit       <= 1'b0;
            Ride_Step <= 1'b0;
            Ride_Dir  <= Direction;
        end else begin
            if (move) begin
                presc <= 5'd0;
            end else if (running) begin
                presc <= presc + 5'd1;
            end
            Ride_Dir <= Direction;
            if (Mode) begin
                Hit       <= in_lane && !any_overlap;
                Ride_Step <= move && any_overlap;
            end else begin
                Hit       <= any_overlap;
                Ride_Step <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obstacle_row.sv
`default_nettype none
// Directed, table-driven bench for obstacle_row with a few multi-cycle sequences.
module tb_obstacle_row;

    localparam logic [10:0] ROW_Y = 11'd100;

    logic             frame_clk = 1'b0;
    logic             Reset, Load, Pause, Mode, Direction;
    logic [3:0]       Number_Objs;
    logic [7:0]       Gap_Size;
    logic [4:0]       Speed;
    logic [10:0]      Row_Y, Frog_X, Frog_Y;
    logic [3:0][10:0] Obj_X;
    logic [3:0]       Obj_Active;
    logic             Hit, Ride_Step, Ride_Dir;

    int errors = 0;
    int checks = 0;

    obstacle_row dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .Load       (Load),
        .Pause      (Pause),
        .Mode       (Mode),
        .Number_Objs(Number_Objs),
        .Gap_Size   (Gap_Size),
        .Speed      (Speed),
        .Direction  (Direction),
        .Row_Y      (Row_Y),
        .Frog_X     (Frog_X),
        .Frog_Y     (Frog_Y),
        .Obj_X      (Obj_X),
        .Obj_Active (Obj_Active),
        .Hit        (Hit),
        .Ride_Step  (Ride_Step),
        .Ride_Dir   (Ride_Dir)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic        rst, ld, pse, md;
        logic [3:0]  nobj;
        logic [7:0]  gap;
        logic [4:0]  spd;
        logic        dir;
        logic [10:0] fx, fy;
        logic [10:0] x0, x1, x2, x3;
        logic [3:0]  act;
        logic        hit, ride;
        logic        chk_rdir, rdir;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(
        input logic rst, ld, pse, md, input logic [3:0] nobj, input logic [7:0] gap,
        input logic [4:0] spd, input logic dir, input logic [10:0] fx, fy,
        input logic [10:0] x0, x1, x2, x3, input logic [3:0] act,
        input logic hit, ride, chk_rdir, rdir);
        vec_t v;
        v.rst = rst; v.ld = ld; v.pse = pse; v.md = md; v.nobj = nobj; v.gap = gap;
        v.spd = spd; v.dir = dir; v.fx = fx; v.fy = fy;
        v.x0 = x0; v.x1 = x1; v.x2 = x2; v.x3 = x3; v.act = act;
        v.hit = hit; v.ride = ride; v.chk_rdir = chk_rdir; v.rdir = rdir;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [47:0] got,
                         input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0d required %0d", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic check_pos(input string name, input int idx,
                             input logic [10:0] x0, x1, x2, x3);
        check({name, " x0"}, idx, 48'(Obj_X[0]), 48'(x0));
        check({name, " x1"}, idx, 48'(Obj_X[1]), 48'(x1));
        check({name, " x2"}, idx, 48'(Obj_X[2]), 48'(x2));
        check({name, " x3"}, idx, 48'(Obj_X[3]), 48'(x3));
    endtask

    initial begin
        Row_Y = ROW_Y;
        //          rst ld ps md nobj gap spd dir fx   fy     x0   x1   x2   x3   act   hit ride cr rd
        vq.push_back(mkv(1, 0, 0, 0, 4, 80,  0, 0,   0, 300,    0, 160, 320, 480, 4'hF, 0, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4, 80, 31, 1,   0, 300,    1, 161, 321, 481, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4, 80, 31, 1,   0, 300,    2, 162, 322, 482, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 1, 0, 4, 80, 31, 1,   0, 300,    2, 162, 322, 482, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4, 80, 30, 1,   0, 300,    2, 162, 322, 482, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4, 80, 30, 1,   0, 300,    3, 163, 323, 483, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4, 80, 30, 1,   0, 300,    3, 163, 323, 483, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4, 80, 31, 0,   0, 300,    2, 162, 322, 482, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 1, 0, 0, 4,  0, 31, 0,   0, 300,    0,  80, 160, 240, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4,  0, 31, 0,   0, 300,  719,  79, 159, 239, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4,  0, 31, 1,   0, 300,    0,  80, 160, 240, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 1, 0, 0, 4, 80,  0, 1,   0, 300,    0, 160, 320, 480, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4, 80,  0, 1, 100, 100,    0, 160, 320, 480, 4'hF, 1, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 1, 80,  0, 1, 100, 100,    0, 160, 320, 480, 4'h1, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 0, 0, 80,  0, 1, 100, 100,    0, 160, 320, 480, 4'h0, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 1, 0, 80,  0, 1, 100, 100,    0, 160, 320, 480, 4'h0, 1, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 1,15, 80,  0, 1, 100, 100,    0, 160, 320, 480, 4'hF, 0, 0, 0, 0));
        vq.push_back(mkv(0, 0, 0, 1, 4, 80, 31, 1, 100, 100,    1, 161, 321, 481, 4'hF, 0, 1, 1, 1));
        vq.push_back(mkv(0, 0, 0, 1, 4, 80, 31, 0, 100, 100,    0, 160, 320, 480, 4'hF, 0, 1, 1, 0));
        vq.push_back(mkv(0, 0, 0, 1, 4, 80, 31, 0, 200, 100,  719, 159, 319, 479, 4'hF, 1, 0, 1, 0));
        vq.push_back(mkv(1, 1, 0, 1, 4,  0, 31, 1, 200, 100,    0,  80, 160, 240, 4'hF, 0, 0, 1, 0));
        vq.push_back(mkv(0, 0, 0, 0, 4,  0, 31, 1, 100, 100,    1,  81, 161, 241, 4'hF, 1, 0, 1, 1));

        foreach (vq[k]) begin
            Reset = vq[k].rst; Load = vq[k].ld; Pause = vq[k].pse; Mode = vq[k].md;
            Number_Objs = vq[k].nobj; Gap_Size = vq[k].gap; Speed = vq[k].spd;
            Direction = vq[k].dir; Frog_X = vq[k].fx; Frog_Y = vq[k].fy;
            tick();
            check_pos("vec", k, vq[k].x0, vq[k].x1, vq[k].x2, vq[k].x3);
            check("vec active", k, 48'(Obj_Active), 48'(vq[k].act));
            check("vec hit", k, 48'(Hit), 48'(vq[k].hit));
            check("vec ride_step", k, 48'(Ride_Step), 48'(vq[k].ride));
            if (vq[k].chk_rdir) check("vec ride_dir", k, 48'(Ride_Dir), 48'(vq[k].rdir));
        end

        // Speed 0 holds the row still for 100 frames.
        Mode = 1'b0; Frog_Y = 11'd300; Speed = 5'd0; Direction = 1'b1;
        for (int f = 0; f < 100; f++) tick();
        check_pos("speed0 hold", 100, 1, 81, 161, 241);

        // Slow count, then speed raised mid-count: must step on the very next frame.
        Speed = 5'd1;
        for (int f = 0; f < 5; f++) tick();
        check_pos("slow count", 5, 1, 81, 161, 241);
        Speed = 5'd31;
        tick();
        check_pos("speed raise", 1, 2, 82, 162, 242);

        // Reset mid-run beats Pause and reloads from the present gap.
        Reset = 1'b1; Pause = 1'b1; Gap_Size = 8'd80;
        tick();
        check_pos("mid reset", 0, 0, 160, 320, 480);
        check("mid reset hit", 0, 48'(Hit), 48'd0);
        Reset = 1'b0;
        tick();
        check_pos("paused after reset", 1, 0, 160, 320, 480);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
